// File: rtl/stage2_group_accumulator_pkg.sv
// Shared types and helpers for the stage2 group accumulator.
package stage2_group_accumulator_pkg;

   // Controller states: waiting for a group, mid-group, result held.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // Working width for the generic extension helpers; callers truncate.
   localparam int unsigned EXT_W = 64;

   // Result width that holds NUM_GROUPS shifted beats without overflow.
   function automatic int unsigned calc_out_width(input int unsigned in_w,
                                                  input int unsigned num_inputs,
                                                  input int unsigned num_groups);
      return in_w + (num_groups - 1) * num_inputs + $clog2(num_groups);
   endfunction

   // Sign-extend the low w bits of x to EXT_W bits.
   function automatic logic [EXT_W-1:0] sext_to(input logic [EXT_W-1:0] x,
                                                input int unsigned      w);
      logic [EXT_W-1:0] mask;
      logic [EXT_W-1:0] sign_bit;
      mask     = (EXT_W'(1) << w) - EXT_W'(1);
      sign_bit = EXT_W'(1) << (w - 1);
      return ((x & sign_bit) != '0) ? (x | ~mask) : (x & mask);
   endfunction

   // Zero-extend the low w bits of x to EXT_W bits.
   function automatic logic [EXT_W-1:0] zext_to(input logic [EXT_W-1:0] x,
                                                input int unsigned      w);
      logic [EXT_W-1:0] mask;
      mask = (EXT_W'(1) << w) - EXT_W'(1);
      return x & mask;
   endfunction

endpackage

// File: rtl/stage2_group_accumulator_if.sv
// Beat input and result output handshakes of the stage2 accumulator.
interface stage2_group_accumulator_if
   import stage2_group_accumulator_pkg::*;
#(
   parameter int unsigned IN_WIDTH  = 13,
   parameter int unsigned OUT_WIDTH = calc_out_width(13, 4, 4)
);
   logic [IN_WIDTH-1:0]  in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic [OUT_WIDTH-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready;

   // Accumulator side: consumes beats, produces results.
   modport slave (
      input  in_data,
      input  in_valid,
      input  out_ready,
      output in_ready,
      output out_data,
      output out_valid
   );

   // Environment side: produces beats, consumes results.
   modport master (
      output in_data,
      output in_valid,
      output out_ready,
      input  in_ready,
      input  out_data,
      input  out_valid
   );
endinterface

// File: rtl/stage2_group_accumulator_shift_accumulate.sv
// Combinational step: acc + (sext(in_data) << group_idx*NUM_INPUTS).
module stage2_group_accumulator_shift_accumulate
   import stage2_group_accumulator_pkg::*;
#(
   parameter int unsigned NUM_INPUTS = 4,
   parameter int unsigned IN_WIDTH   = 13,
   parameter int unsigned OUT_WIDTH  = 27,
   parameter int unsigned GIDX_W     = 2
) (
   input  logic [OUT_WIDTH-1:0] acc_i,
   input  logic [IN_WIDTH-1:0]  in_data_i,
   input  logic [GIDX_W-1:0]    group_idx_i,
   output logic [OUT_WIDTH-1:0] acc_next_o
);

   logic [OUT_WIDTH-1:0] beat_ext;
   int unsigned          shamt;

   // Weight the beat by its position in the group and add it in.
   always_comb begin
      beat_ext   = OUT_WIDTH'(sext_to(EXT_W'(in_data_i), IN_WIDTH));
      shamt      = 32'(group_idx_i) * NUM_INPUTS;
      acc_next_o = acc_i + (beat_ext << shamt);
   end

endmodule

// File: rtl/stage2_group_accumulator.sv
// Stage2: shift-accumulates NUM_GROUPS stage1 beats into one wide result,
// or forwards each beat zero-extended when bypass is selected.
module stage2_group_accumulator
   import stage2_group_accumulator_pkg::*;
#(
   parameter int unsigned NUM_INPUTS = 4,
   parameter int unsigned IN_WIDTH   = 13,
   parameter int unsigned NUM_GROUPS = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                DISABLE_STAGE_2,
   stage2_group_accumulator_if.slave           bus,
   output logic [$clog2(NUM_GROUPS)-1:0]       group_idx
);

   localparam int unsigned OUT_WIDTH = calc_out_width(IN_WIDTH, NUM_INPUTS, NUM_GROUPS);
   localparam int unsigned GIDX_W    = $clog2(NUM_GROUPS);
   localparam logic [GIDX_W-1:0] LAST_IDX = GIDX_W'(NUM_GROUPS - 1);

   state_t               state_q,     state_d;
   logic [OUT_WIDTH-1:0] acc_q,       acc_d;
   logic [OUT_WIDTH-1:0] out_data_q,  out_data_d;
   logic                 out_valid_q, out_valid_d;
   logic [GIDX_W-1:0]    group_idx_q, group_idx_d;
   logic                 mode_q,      mode_d;

   logic                 in_ready_c;
   logic                 start_beat;
   logic [OUT_WIDTH-1:0] acc_next;

   stage2_group_accumulator_shift_accumulate #(
      .NUM_INPUTS (NUM_INPUTS),
      .IN_WIDTH   (IN_WIDTH),
      .OUT_WIDTH  (OUT_WIDTH),
      .GIDX_W     (GIDX_W)
   ) u_shift_accumulate (
      .acc_i       (acc_q),
      .in_data_i   (bus.in_data),
      .group_idx_i (group_idx_q),
      .acc_next_o  (acc_next)
   );

   // Next-state and datapath decisions; a drained DONE behaves like IDLE.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      group_idx_d = group_idx_q;
      mode_d      = mode_q;
      in_ready_c  = 1'b1;
      start_beat  = 1'b0;

      case (state_q)
         S_IDLE: begin
            start_beat = bus.in_valid;
         end
         S_ACCUM: begin
            in_ready_c = !mode_q;
            if (bus.in_valid && !mode_q) begin
               acc_d = acc_next;
               if (group_idx_q == LAST_IDX) begin
                  out_data_d  = acc_next;
                  out_valid_d = 1'b1;
                  group_idx_d = '0;
                  state_d     = S_DONE;
               end else begin
                  group_idx_d = group_idx_q + GIDX_W'(1);
               end
            end
         end
         S_DONE: begin
            in_ready_c = bus.out_ready;
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
               start_beat  = bus.in_valid;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (start_beat) begin
         mode_d = DISABLE_STAGE_2;
         if (DISABLE_STAGE_2) begin
            out_data_d  = OUT_WIDTH'(zext_to(EXT_W'(bus.in_data), IN_WIDTH));
            out_valid_d = 1'b1;
            group_idx_d = '0;
            state_d     = S_DONE;
         end else begin
            acc_d       = OUT_WIDTH'(sext_to(EXT_W'(bus.in_data), IN_WIDTH));
            out_valid_d = 1'b0;
            group_idx_d = GIDX_W'(1);
            state_d     = S_ACCUM;
         end
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         group_idx_q <= '0;
         mode_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         group_idx_q <= group_idx_d;
         mode_q      <= mode_d;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign group_idx     = group_idx_q;

endmodule

// File: tb/tb_stage2_group_accumulator.sv
// Bench for stage2_group_accumulator: vector table, directed corner
// sequences, and a random run checked every cycle against a sum model.
module tb_stage2_group_accumulator;

   logic       clk = 1'b0;
   logic       rst;
   logic       dis;
   logic [1:0] group_idx;

   stage2_group_accumulator_if #(.IN_WIDTH(13), .OUT_WIDTH(27)) bus ();

   stage2_group_accumulator dut (
      .clk             (clk),
      .rst             (rst),
      .DISABLE_STAGE_2 (dis),
      .bus             (bus.slave),
      .group_idx       (group_idx)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [26:0] exp_q[$];
   int          k         = 0;
   longint      sum       = 0;
   int          acc_groups = 0;
   bit          mon_en    = 1'b0;

   function automatic longint sval(input logic [12:0] b);
      return b[12] ? (longint'(b) - 64'sd8192) : longint'(b);
   endfunction

   // Every negedge: compare DUT with the model, then apply this cycle's handshakes.
   always @(negedge clk) begin
      if (mon_en) begin
         bit exp_valid;
         bit beat_ok;
         exp_valid = (exp_q.size() != 0);
         chk("mon_out_valid", 64'(bus.out_valid), 64'(exp_valid));
         if (exp_valid) chk("mon_out_data", 64'(bus.out_data), 64'(exp_q[0]));
         chk("mon_in_ready", 64'(bus.in_ready), 64'(!exp_valid || bus.out_ready));
         chk("mon_group_idx", 64'(group_idx), 64'(k));
         if (rst) begin
            exp_q.delete();
            k = 0;
         end else begin
            beat_ok = bus.in_valid && (!exp_valid || bus.out_ready);
            if (exp_valid && bus.out_ready) void'(exp_q.pop_front());
            if (beat_ok) begin
               if (k == 0 && dis) begin
                  exp_q.push_back(27'(bus.in_data));
               end else if (k == 0) begin
                  sum = sval(bus.in_data);
                  k   = 1;
               end else begin
                  sum = sum + sval(bus.in_data) * (longint'(1) << (4 * k));
                  k   = k + 1;
                  if (k == 4) begin
                     exp_q.push_back(27'(sum));
                     k = 0;
                     acc_groups++;
                  end
               end
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [12:0] d);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      sync();
   endtask

   typedef struct packed {
      logic [3:0][12:0] beats;
      logic [26:0]      exp;
   } vec_t;

   function automatic vec_t mk(input logic [12:0] a, input logic [12:0] b,
                               input logic [12:0] c, input logic [12:0] d,
                               input logic [26:0] e);
      vec_t v;
      v.beats[0] = a;
      v.beats[1] = b;
      v.beats[2] = c;
      v.beats[3] = d;
      v.exp      = e;
      return v;
   endfunction

   vec_t vecs[9];

   initial begin
      int g0;
      int cyc;

      vecs[0] = mk(13'h0001, 13'h0001, 13'h0001, 13'h0001, 27'h0001111);
      vecs[1] = mk(13'h1FFF, 13'h0000, 13'h0000, 13'h0000, 27'h7FFFFFF);
      vecs[2] = mk(13'h0FFF, 13'h0FFF, 13'h0FFF, 13'h0FFF, 27'h110FEEF);
      vecs[3] = mk(13'h0002, 13'h0000, 13'h0000, 13'h0000, 27'h0000002);
      vecs[4] = mk(13'h0000, 13'h0000, 13'h0000, 13'h1FFF, 27'h7FFF000);
      vecs[5] = mk(13'h1000, 13'h0000, 13'h0000, 13'h0000, 27'h7FFF000);
      vecs[6] = mk(13'h000F, 13'h000F, 13'h000F, 13'h000F, 27'h000FFFF);
      vecs[7] = mk(13'h1000, 13'h1000, 13'h1000, 13'h1000, 27'h6EEF000);
      vecs[8] = mk(13'h1FFF, 13'h0001, 13'h0000, 13'h0000, 27'h000000F);

      rst           = 1'b1;
      dis           = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
      chk("reset_out_data",  64'(bus.out_data),  64'd0);
      chk("reset_group_idx", 64'(group_idx),     64'd0);
      chk("reset_in_ready",  64'(bus.in_ready),  64'd1);
      sync();
      rst    = 1'b0;
      mon_en = 1'b1;

      // Table: four back-to-back beats, result one cycle after the last.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         for (int j = 0; j < 4; j++) beat(vecs[i].beats[j]);
         bus.in_valid = 1'b0;
         @(negedge clk);
         chk($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'd1);
         chk($sformatf("vec%0d_data", i),  64'(bus.out_data),  64'(vecs[i].exp));
         sync();
         @(negedge clk);
         chk($sformatf("vec%0d_drop", i),  64'(bus.out_valid), 64'd0);
         sync();
      end

      // Backpressure: result held, no beat accepted, then drain + accept together.
      bus.out_ready = 1'b0;
      for (int j = 0; j < 4; j++) beat(13'h0001);
      bus.in_valid = 1'b1;
      bus.in_data  = 13'h0005;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
         chk("bp_out_data",  64'(bus.out_data),  64'h0001111);
         chk("bp_in_ready",  64'(bus.in_ready),  64'd0);
         chk("bp_group_idx", 64'(group_idx),     64'd0);
         sync();
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_drain_in_ready", 64'(bus.in_ready), 64'd1);
      sync();
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("bp_next_valid", 64'(bus.out_valid), 64'd0);
      chk("bp_next_idx",   64'(group_idx),     64'd1);
      sync();
      for (int j = 0; j < 3; j++) beat(13'h0000);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("bp_next_data", 64'(bus.out_data), 64'h0000005);
      sync();

      // Bypass streaming at one beat per cycle.
      dis = 1'b1;
      beat(13'h0005);
      bus.in_valid = 1'b1;
      bus.in_data  = 13'h1FFF;
      @(negedge clk);
      chk("byp0_valid", 64'(bus.out_valid), 64'd1);
      chk("byp0_data",  64'(bus.out_data),  64'h0000005);
      chk("byp0_ready", 64'(bus.in_ready),  64'd1);
      sync();
      bus.in_valid = 1'b0;
      dis          = 1'b0;
      @(negedge clk);
      chk("byp1_valid", 64'(bus.out_valid), 64'd1);
      chk("byp1_data",  64'(bus.out_data),  64'h0001FFF);
      sync();
      @(negedge clk);
      chk("byp_drop", 64'(bus.out_valid), 64'd0);
      sync();

      // Bypass select toggled mid-group is ignored.
      beat(13'h0001);
      bus.in_valid = 1'b0;
      dis          = 1'b1;
      @(negedge clk);
      chk("tog_idx",   64'(group_idx),     64'd1);
      chk("tog_valid", 64'(bus.out_valid), 64'd0);
      sync();
      for (int j = 0; j < 3; j++) beat(13'h0001);
      bus.in_valid = 1'b0;
      dis          = 1'b0;
      @(negedge clk);
      chk("tog_data", 64'(bus.out_data), 64'h0001111);
      sync();

      // Reset mid-group (with a beat offered) discards the partial sum.
      beat(13'h0007);
      beat(13'h0007);
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 13'h0009;
      sync();
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("rst_mid_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_mid_idx",   64'(group_idx),     64'd0);
      sync();
      beat(13'h0002);
      for (int j = 0; j < 3; j++) beat(13'h0000);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("rst_next_data", 64'(bus.out_data), 64'h0000002);
      sync();

      // Random gaps, backpressure and occasional bypass beats.
      g0  = acc_groups;
      cyc = 0;
      while (acc_groups - g0 < 100 && cyc < 20000) begin
         bus.in_valid  = ($urandom_range(0, 2) != 0);
         bus.in_data   = 13'($urandom);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         dis           = ($urandom_range(0, 9) == 0);
         sync();
         cyc++;
      end
      checks++;
      if (acc_groups - g0 < 100) begin
         failures++;
         $display("FAIL rand_groups actual=%0d required=100", acc_groups - g0);
      end

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      dis           = 1'b0;
      repeat (3) sync();
      @(negedge clk);
      chk("final_out_valid", 64'(bus.out_valid), 64'd0);
      sync();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
